dmem_wait_model: RTL and testbench

Parametrised, byte-enabled data memory for the pipelined MIPS core. It is the successor to the bench-level combinational data array. The core issues single-word requests over a req/ready handshake. The memory answers after a configurable number of wait states, performs a hardware flash-clear after reset, and flags illegal accesses. It sits between the core's M stage and the bench, so stall logic can be exercised against a non-zero-latency memory.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_byte_merge.sv | 22 ++
 rtl/dmem_wait_model.sv | 176 +++++++++++++++++
 tb/tb_dmem_wait_model.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and helpers for the wait-state data memory model.
//   dmem_state_e   : controller states (CLEAR, IDLE, WAIT, RESP)
//   LAT_W          : width of the wait-state counter (LATENCY 0..15)
//   LANE_*         : byte-enable patterns the memory accepts
//   byteen_legal() : 1 when a byte-enable pattern is an accepted access shape
package dmem_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dmem_state_e;

  localparam logic [3:0] LANE_NONE = 4'b0000;  // read
  localparam logic [3:0] LANE_B0   = 4'b0001;
  localparam logic [3:0] LANE_B1   = 4'b0010;
  localparam logic [3:0] LANE_B2   = 4'b0100;
  localparam logic [3:0] LANE_B3   = 4'b1000;
  localparam logic [3:0] LANE_H0   = 4'b0011;
  localparam logic [3:0] LANE_H1   = 4'b1100;
  localparam logic [3:0] LANE_W    = 4'b1111;

  // Byte, aligned halfword, full word, or read; anything else is rejected.
  function automatic logic byteen_legal(input logic [3:0] be);
    case (be)
      LANE_NONE, LANE_B0, LANE_B1, LANE_B2, LANE_B3,
      LANE_H0, LANE_H1, LANE_W: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge
// Combinational byte-lane merge: each enabled lane takes the write data byte,
// every other lane keeps the old word's byte.
//   old_word [31:0] in  : current memory word
//   wdata    [31:0] in  : lane-aligned write data
//   byteen   [3:0]  in  : lane enables, bit i selects bits [8i+7:8i]
//   new_word [31:0] out : merged word
module dmem_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) new_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_wait_model.sv
// dmem_wait_model
// Byte-enabled data memory with configurable wait states, a flash-clear sweep
// after reset and illegal-access flagging.
// Parameters: DEPTH_WORDS (power of two), BASE_ADDR (byte address of word 0),
//             LATENCY (wait states, 0..15).
// Ports:
//   clk, reset (async, active-low)
//   req, m_data_addr, m_data_byteen, m_data_wdata, m_inst_addr : request side
//   busy, ready, m_data_rdata, err                            : response side
//   dbg_state                                                 : controller state
// Optional build macro DMEM_TRACE_EN: prints one line per legal write commit;
// without it m_inst_addr is unused.
//
// Handshake: a request is taken on a rising edge when req=1 and the state is
// IDLE or RESP; busy=1 means a further request would be dropped. ready is a
// one-cycle strobe, m_data_rdata/err are valid with it and hold until the next
// commit edge. Accept at edge k gives ready during cycle k+1+LATENCY.
module dmem_wait_model
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] m_data_addr,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_wdata,
  input  logic [31:0] m_inst_addr,
  output logic        busy,
  output logic        ready,
  output logic [31:0] m_data_rdata,
  output logic        err,
  output dmem_state_e dbg_state
);

  localparam int               AW  = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);

  dmem_state_e      state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    clr_idx_q;
  logic [31:0]      h_addr, h_wdata;
  logic [3:0]       h_be;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, commit_live, commit_held, commit;
  logic [31:0] c_addr, c_wdata, c_off, old_word, merged, mem_wdata;
  logic [3:0]  c_be;
  logic        in_range, legal, mem_we;
  logic [AW-1:0] mem_addr;

  assign accept      = (state_q == ST_IDLE || state_q == ST_RESP) && req;
  // With zero wait states the commit happens on the accept edge itself, so
  // the live request fields feed the datapath instead of the holding regs.
  assign commit_live = accept && (LATENCY == 0);
  // Counter was loaded with LATENCY; the edge that takes it to 0 commits.
  assign commit_held = (state_q == ST_WAIT) && (cnt_q == LAT_W'(1));
  assign commit      = commit_live || commit_held;

  assign c_addr  = commit_live ? m_data_addr   : h_addr;
  assign c_be    = commit_live ? m_data_byteen : h_be;
  assign c_wdata = commit_live ? m_data_wdata  : h_wdata;

  // Unsigned offset; only meaningful when c_addr >= BASE_ADDR (checked first).
  assign c_off    = c_addr - BASE_ADDR;
  assign in_range = (c_addr >= BASE_ADDR) && (c_off[31:2] < 30'(DEPTH_WORDS));
  assign legal    = in_range && byteen_legal(c_be);

  // Single port: the clear sweep owns the array while in CLEAR.
  assign mem_addr  = (state_q == ST_CLEAR) ? clr_idx_q : c_off[AW+1:2];
  assign old_word  = mem[mem_addr];
  assign mem_wdata = (state_q == ST_CLEAR) ? 32'h0 : merged;
  assign mem_we    = (state_q == ST_CLEAR) ||
                     (commit && legal && (c_be != LANE_NONE));

  dmem_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (c_wdata),
    .byteen   (c_be),
    .new_word (merged)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_idx_q == AW'(DEPTH_WORDS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (req) begin
          cnt_d = LAT;
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            busy    = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) state_d = ST_RESP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      clr_idx_q <= '0;
      h_addr    <= '0;
      h_be      <= '0;
      h_wdata   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Wraps back to 0 after the last word, ready for the next sweep.
      if (state_q == ST_CLEAR) clr_idx_q <= clr_idx_q + AW'(1);
      if (accept) begin
        h_addr  <= m_data_addr;
        h_be    <= m_data_byteen;
        h_wdata <= m_data_wdata;
      end
      if (commit) begin
        err_q   <= !legal;
        rdata_q <= (legal && c_be == LANE_NONE) ? old_word : 32'h0;
      end
    end
  end

  assign ready        = (state_q == ST_RESP);
  assign m_data_rdata = rdata_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

  logic unused_off;
  assign unused_off = ^c_off[1:0];

`ifdef DMEM_TRACE_EN
  logic [31:0] h_inst, c_inst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      h_inst <= '0;
    else if (accept) h_inst <= m_inst_addr;
  end

  assign c_inst = commit_live ? m_inst_addr : h_inst;

  always @(posedge clk) begin
    if (reset && state_q != ST_CLEAR && mem_we)
      $display("%d@%h: *%h <= %h", $time, c_inst, {c_addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_inst;
  assign unused_inst = ^m_inst_addr;
`endif

endmodule

// File: tb/tb_dmem_wait_model.sv
// tb_dmem_wait_model
// Directed bench for dmem_wait_model with DEPTH_WORDS=16 at three latencies
// (0, 3, 5). All instances share reset and request fields; each has its own req.
module tb_dmem_wait_model;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_l0 = 1'b0, req_l3 = 1'b0, req_l5 = 1'b0;
  logic [31:0] addr = '0, wdata = '0, inst = '0;
  logic [3:0]  byteen = '0;

  logic        busy_l0, busy_l3, busy_l5;
  logic        ready_l0, ready_l3, ready_l5;
  logic [31:0] rdata_l0, rdata_l3, rdata_l5;
  logic        err_l0, err_l3, err_l5;
  dmem_state_e st_l0, st_l3, st_l5;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_wait_model #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req(req_l0), .m_data_addr(addr),
    .m_data_byteen(byteen), .m_data_wdata(wdata), .m_inst_addr(inst),
    .busy(busy_l0), .ready(ready_l0), .m_data_rdata(rdata_l0), .err(err_l0),
    .dbg_state(st_l0));

  dmem_wait_model #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req(req_l3), .m_data_addr(addr),
    .m_data_byteen(byteen), .m_data_wdata(wdata), .m_inst_addr(inst),
    .busy(busy_l3), .ready(ready_l3), .m_data_rdata(rdata_l3), .err(err_l3),
    .dbg_state(st_l3));

  dmem_wait_model #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(5)) u_l5 (
    .clk(clk), .reset(reset), .req(req_l5), .m_data_addr(addr),
    .m_data_byteen(byteen), .m_data_wdata(wdata), .m_inst_addr(inst),
    .busy(busy_l5), .ready(ready_l5), .m_data_rdata(rdata_l5), .err(err_l5),
    .dbg_state(st_l5));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ready_l0;
      1:       return ready_l3;
      default: return ready_l5;
    endcase
  endfunction

  function automatic logic [31:0] rdat(input int sel);
    case (sel)
      0:       return rdata_l0;
      1:       return rdata_l3;
      default: return rdata_l5;
    endcase
  endfunction

  function automatic logic erro(input int sel);
    case (sel)
      0:       return err_l0;
      1:       return err_l3;
      default: return err_l5;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int sel, input logic v);
    case (sel)
      0:       req_l0 = v;
      1:       req_l3 = v;
      default: req_l5 = v;
    endcase
  endtask

  // Called at a negedge; returns at the negedge where ready is seen.
  // lat counts negedges from request presentation to ready (-1 on timeout).
  task automatic access(input int sel, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output int lat);
    addr = a; byteen = be; wdata = d; inst = 32'h0040_0000 + a;
    set_req(sel, 1'b1);
    @(negedge clk);
    set_req(sel, 1'b0);
    lat = 1;
    while (!rdy(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rdy(sel)) lat = -1;
    rd = rdat(sel);
    e  = erro(sel);
  endtask

  // Called at the negedge where reset is released: busy for 16 samples, then 0.
  task automatic expect_clear(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_busy"}, busy_l5, 1'b1);
      check({tag, "_no_ready"}, ready_l5, 1'b0);
      @(negedge clk);
    end
    check({tag, "_busy_done"}, busy_l5, 1'b0);
    check({tag, "_idle"}, 32'(st_l5), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        e;
  int          lat;
  logic [31:0] vals [4];

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy_l3, 1'b1);
    check("rst_ready", ready_l3, 1'b0);
    check("rst_err", err_l3, 1'b0);
    check("rst_rdata", rdata_l3, 32'h0);
    check("rst_state", 32'(st_l3), 32'(ST_CLEAR));

    // Clear sweep: 16 busy cycles
    reset = 1'b1;
    expect_clear("clear1");
    check("clear1_l3_busy", busy_l3, 1'b0);
    check("clear1_l0_busy", busy_l0, 1'b0);

    // Read of cleared word 0
    access(1, 32'h0, 4'b0000, 32'h0, rd, e, lat);
    check("rd0_data", rd, 32'h0);
    check("rd0_err", e, 1'b0);
    check("rd0_lat", lat, 4);

    // LATENCY=3 full-word write then read
    access(1, 32'h10, 4'b1111, 32'hDEAD_BEEF, rd, e, lat);
    check("wr10_lat", lat, 4);
    check("wr10_err", e, 1'b0);
    access(1, 32'h10, 4'b0000, 32'h0, rd, e, lat);
    check("rd10_data", rd, 32'hDEAD_BEEF);

    // Byte lanes
    access(1, 32'h20, 4'b1111, 32'h1234_5678, rd, e, lat);
    access(1, 32'h20, 4'b0100, 32'h00AA_0000, rd, e, lat);
    access(1, 32'h20, 4'b0000, 32'h0, rd, e, lat);
    check("lane_b2", rd, 32'h12AA_5678);
    access(1, 32'h20, 4'b0011, 32'h0000_CCDD, rd, e, lat);
    access(1, 32'h20, 4'b0000, 32'h0, rd, e, lat);
    check("lane_h0", rd, 32'h12AA_CCDD);

    // Illegal byteen
    access(1, 32'h20, 4'b0101, 32'hFFFF_FFFF, rd, e, lat);
    check("bad_be_err", e, 1'b1);
    check("bad_be_lat", lat, 4);
    access(1, 32'h20, 4'b0000, 32'h0, rd, e, lat);
    check("bad_be_unchanged", rd, 32'h12AA_CCDD);
    check("bad_be_rd_err", e, 1'b0);

    // Out-of-range address
    access(1, 32'h40, 4'b0000, 32'h0, rd, e, lat);
    check("oor_err", e, 1'b1);
    check("oor_rdata", rd, 32'h0);
    @(negedge clk);
    check("oor_ready_drop", ready_l3, 1'b0);
    check("oor_err_hold", err_l3, 1'b1);

    // Last word, low address bits ignored
    access(1, 32'h3C, 4'b1111, 32'hA5A5_0F0F, rd, e, lat);
    check("last_wr_err", e, 1'b0);
    access(1, 32'h3F, 4'b0000, 32'h0, rd, e, lat);
    check("last_rd", rd, 32'hA5A5_0F0F);
    check("last_rd_err", e, 1'b0);

    // LATENCY=0: fill four words, then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'h1111_0000 + 32'(i * 32'h0101);
      access(0, 32'(4 * i), 4'b1111, vals[i], rd, e, lat);
    end
    check("l0_lat", lat, 1);
    addr = 32'h0; byteen = 4'b0000; req_l0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_ready", ready_l0, 1'b1);
      check("b2b_data", rdata_l0, vals[i]);
      check("b2b_busy", busy_l0, 1'b0);
      if (i < 3) addr = 32'(4 * (i + 1));
      else       req_l0 = 1'b0;
    end
    @(negedge clk);
    check("b2b_end", ready_l0, 1'b0);

    // LATENCY=5: committed write, then a write cut off by reset
    access(2, 32'h8, 4'b1111, 32'hCAFE_F00D, rd, e, lat);
    check("l5_lat", lat, 6);
    access(2, 32'h8, 4'b0000, 32'h0, rd, e, lat);
    check("l5_rd", rd, 32'hCAFE_F00D);
    @(negedge clk);
    addr = 32'h8; byteen = 4'b1111; wdata = 32'h0BAD_BEEF; req_l5 = 1'b1;
    @(negedge clk);
    req_l5 = 1'b0;
    @(negedge clk);
    check("mid_wait", 32'(st_l5), 32'(ST_WAIT));
    reset = 1'b0;
    #1;
    check("mid_ready", ready_l5, 1'b0);
    check("mid_busy", busy_l5, 1'b1);
    check("mid_state", 32'(st_l5), 32'(ST_CLEAR));
    @(negedge clk);
    reset = 1'b1;
    expect_clear("clear2");
    access(2, 32'h8, 4'b0000, 32'h0, rd, e, lat);
    check("mid_cleared", rd, 32'h0);
    access(1, 32'h10, 4'b0000, 32'h0, rd, e, lat);
    check("l3_cleared", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
